// File: rtl/seg7_scan.sv
// Scans a captured 8-digit BCD value and sign onto a common-anode 7-segment display.
// Outputs are registered, so they lag the scan index by one cycle. No backpressure: a capture is taken whenever valid_in is high.
module seg7_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] bcd,
  input  logic        sign,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_ERR   = 7'h06;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   bcd_q, bcd_d;
  logic          sign_q, sign_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic [2:0]    msd;
  logic          nonzero;
  logic [3:0]    cur_digit;
  logic          show_minus;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = SEG_ERR;
    endcase
  endfunction

  // Refresh prescaler, digit index and capture registers.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    bcd_d   = valid_in ? bcd  : bcd_q;
    sign_d  = valid_in ? sign : sign_q;
  end

  // Most significant nonzero digit; invalid nibbles count as nonzero.
  always_comb begin
    msd     = 3'd0;
    nonzero = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        msd     = 3'(k);
        nonzero = 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit  = bcd_q[{idx_q, 2'b00} +: 4];
    show_minus = sign_q && nonzero && ({1'b0, idx_q} == ({1'b0, msd} + 4'd1));
    an_d       = ~(8'b1 << idx_q);
    if (idx_q <= msd) begin
      seg_d = glyph(cur_digit);
    end else if (show_minus) begin
      seg_d = SEG_MINUS;
    end else begin
      seg_d = SEG_BLANK;
    end
    // A full-width negative has no room for '-', so the point on digit 7 marks it.
    dp_d = ~(sign_q && nonzero && (msd == 3'd7) && (idx_q == 3'd7));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      bcd_q   <= 32'd0;
      sign_q  <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized and directed bench for seg7_scan against a slot-arithmetic display model.
module tb_seg7_scan;

  localparam int CLK_DIV = 4;
  localparam logic [15:0] DARK = {8'hFF, 7'h7F, 1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] bcd;
  logic        sign;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .bcd      (bcd),
    .sign     (sign),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] digit_glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model state: cycles since reset release, captured value, expected outputs.
  int          m_cyc   = 0;
  logic [31:0] m_bcd   = 32'd0;
  logic        m_sign  = 1'b0;
  logic [15:0] m_exp   = DARK;
  bit          m_known = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
               tag, $time, obs[15:8], obs[7:1], obs[0], exp[15:8], exp[7:1], exp[0]);
    end
  endtask

  // What the display should show while digit position 'slot' is lit.
  function automatic logic [15:0] ref_disp(input int slot, input logic [31:0] b, input logic s);
    int         top;
    int         d;
    bit         nz;
    logic [6:0] g;
    logic       p;
    logic [7:0] a;
    top = 0;
    for (int k = 0; k < 8; k++)
      if (((b >> (4 * k)) & 32'hF) != 0) top = k;
    nz = (b != 0);
    d  = int'((b >> (4 * slot)) & 32'hF);
    if (slot <= top)                      g = (d > 9) ? 7'h06 : digit_glyph[d];
    else if (s && nz && slot == top + 1)  g = 7'h3F;
    else                                  g = 7'h7F;
    p = !(s && nz && top == 7 && slot == 7);
    a = 8'hFF ^ (8'h01 << slot);
    return {a, g, p};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_exp   <= DARK;
      m_cyc   <= 0;
      m_bcd   <= 32'd0;
      m_sign  <= 1'b0;
      m_known <= 1'b1;
    end else if (m_known) begin
      m_exp <= ref_disp((m_cyc / CLK_DIV) % 8, m_bcd, m_sign);
      m_cyc <= m_cyc + 1;
      if (valid_in) begin
        m_bcd  <= bcd;
        m_sign <= sign;
      end
    end
  end

  task automatic cycle(input string tag, input logic r, input logic v,
                       input logic [31:0] b, input logic s);
    rst = r; valid_in = v; bcd = b; sign = s;
    @(posedge clk);
    @(negedge clk);
    if (m_known) check_val(tag, {an, seg, dp}, m_exp);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, $urandom, $urandom_range(0, 1));
  endtask

  task automatic load(input string tag, input logic [31:0] b, input logic s, input int n);
    cycle(tag, 1'b0, 1'b1, b, s);
    run(tag, n);
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    int          len;
    v   = 32'd0;
    len = $urandom_range(0, 8);
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 15) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
      else                            v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    rst = 1'b1; valid_in = 1'b0; bcd = 32'd0; sign = 1'b0;

    for (int i = 0; i < 3; i++) cycle("reset", 1'b1, 1'b0, 32'd0, 1'b0);
    check_val("reset_dark", {an, seg, dp}, DARK);
    cycle("release", 1'b0, 1'b0, 32'd0, 1'b0);
    check_val("first_digit", {an, seg, dp}, {8'hFE, 7'h40, 1'b1});
    run("idle_zero", 40);

    load("pos_1234", 32'h00001234, 1'b0, 40);
    load("neg_42", 32'h00000042, 1'b1, 40);
    load("neg_full", 32'h12345678, 1'b1, 40);
    load("neg_zero", 32'h00000000, 1'b1, 40);
    load("invalid_a", 32'h0000000A, 1'b0, 40);
    load("neg_7digit", 32'h01000000, 1'b1, 40);

    // Capture exactly on the prescaler wrap.
    while ((m_cyc % CLK_DIV) != CLK_DIV - 1) cycle("align", 1'b0, 1'b0, 32'd0, 1'b0);
    load("tick_capture", 32'h00987654, 1'b1, 20);
    for (int i = 0; i < 2; i++) cycle("mid_reset", 1'b1, 1'b0, 32'd0, 1'b0);
    check_val("mid_reset_dark", {an, seg, dp}, DARK);
    cycle("restart", 1'b0, 1'b0, 32'd0, 1'b0);
    check_val("restart_idx0", {an, seg, dp}, {8'hFE, 7'h40, 1'b1});
    run("restart_run", 12);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        cycle("rand_rst", 1'b1, $urandom_range(0, 1), rand_bcd(), $urandom_range(0, 1));
      else
        cycle("rand", 1'b0, ($urandom_range(0, 15) == 0), rand_bcd(), $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
